dmem_unit: RTL and testbench
============================

DMEM_UNIT -- requirements
Module: dmem_unit

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096; RAM size in 32-bit words, power of two.
REQ-002 Parameter TX_DEPTH, default 8; console FIFO entries, power of two, >= 2.
REQ-003 Parameter MMIO_BASE, default 32'h8000_0000; base of 32-byte MMIO window.
REQ-004 clk  in  1  single clock, all state on posedge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 dmemAddr  in  32  byte address from core M stage.
REQ-007 dmemWdata  in  32  store data, byte/half in low bits.
REQ-008 dmemSize  in  3  funct3 size code.
REQ-009 dmemWen  in  1  store strobe.
REQ-010 dmemRdata  out  32  extended load data, same cycle.
REQ-011 txData  out  8  FIFO head byte.
REQ-012 txValid  out  1  FIFO non-empty.
REQ-013 txReady  in  1  consumer accepts head when txValid&txReady.
REQ-014 halt  out  1  sticky, set by tohost write.
REQ-015 haltCode  out  32  value of first nonzero tohost write.
REQ-016 misalignErr  out  1  sticky misaligned-store flag.

Function
REQ-017 Reads combinational, no side effects; dmemAddr/dmemSize driven every cycle for non-memory instructions, so unit never changes state on a read.
REQ-018 Sizes: 000 B signed, 001 H signed, 010 W, 100 BU, 101 HU; 011/110/111 read as W, stores with these codes ignored.
REQ-019 Load path: aligned word at dmemAddr[AW+1:2] shifted right by 8*dmemAddr[1:0], then truncated and sign/zero-extended per size; no misalign flag on loads.
REQ-020 RAM address: dmemAddr < 4*DEPTH_WORDS; other non-MMIO addresses read 0, writes dropped.
REQ-021 Stores write on posedge via byte strobes: SB lane addr[1:0], SH lanes {addr[1],0} pair, SW all lanes.
REQ-022 Misaligned store (SH addr[0]=1, SW addr[1:0]!=0) suppressed, misalignErr set next edge.
REQ-023 Read of address written same cycle returns old contents.
REQ-024 MMIO +0x00 TX: any store pushes wdata[7:0]; reads 0.
REQ-025 MMIO +0x04 STATUS read: [0] full, [1] empty, [15:8] count, [31:16] overflow count (saturating 16-bit).
REQ-026 MMIO +0x08/+0x0C: cycle counter low/high; 64-bit, +1 every cycle out of reset, wraps to 0.
REQ-027 MMIO +0x10 TOHOST: nonzero store with halt=0 sets halt, latches haltCode; later writes ignored; reads haltCode.
REQ-028 Other MMIO offsets read 0, writes ignored; MMIO accesses ignore dmemSize for reads (full word).
REQ-029 FIFO push accepted if count<TX_DEPTH or pop same cycle; otherwise byte dropped, overflow count +1.
REQ-030 Simultaneous push+pop: count unchanged; on empty, pushed byte appears on txData next cycle (no bypass).
REQ-031 While halt=1 all stores (RAM and MMIO) ignored; FIFO drains, counter runs.

Reset
REQ-032 rst=0 at posedge: FIFO empty, txValid=0, counter=0, overflow=0, halt=0, haltCode=0, misalignErr=0.
REQ-033 RAM contents not reset; a store coincident with reset is dropped.
REQ-034 Reset mid-drain discards queued bytes; txValid low first cycle after reset.

Structure
REQ-035 Package dmem_pkg: size-code enum, MMIO offset constants, STATUS bit positions.
REQ-036 One sub-module tx_fifo (parameterised depth, push/pop/full/empty/count); rest inline.

Verification
REQ-037 SW 0xDEADBEEF @0x100; LB @0x103 -> 0xFFFFFFDE; LHU @0x102 -> 0x0000DEAD; LW -> 0xDEADBEEF.
REQ-038 SH 0x1234 @0x101 -> RAM unchanged, misalignErr=1 next cycle, stays 1 until reset.
REQ-039 txReady=0, 9 stores to TX with TX_DEPTH=8 -> STATUS full=1, count=8, overflow=1; raise txReady -> 8 bytes in order, then txValid=0.
REQ-040 Empty FIFO, push 0x41 with txReady=1 -> txValid next cycle, txData=0x41, STATUS empty after pop.
REQ-041 Store 0x2A then 0x7 to TOHOST -> halt=1, haltCode=0x2A; later SW @0x100 has no effect.
REQ-042 Read counter 10 cycles after reset release -> low=10 (+/-pipeline offset fixed by bench), high=0; force low=0xFFFFFFFF -> high increments next cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory unit: load/store size codes, MMIO
// register offsets and STATUS register bit positions.
package dmem_pkg;

  typedef enum logic [2:0] {
    SizeB  = 3'b000,
    SizeH  = 3'b001,
    SizeW  = 3'b010,
    SizeBu = 3'b100,
    SizeHu = 3'b101
  } size_e;

  localparam logic [4:0] MmioTx     = 5'h00;
  localparam logic [4:0] MmioStatus = 5'h04;
  localparam logic [4:0] MmioCycLo  = 5'h08;
  localparam logic [4:0] MmioCycHi  = 5'h0C;
  localparam logic [4:0] MmioToHost = 5'h10;

  localparam int unsigned StatusFullBit  = 0;
  localparam int unsigned StatusEmptyBit = 1;
  localparam int unsigned StatusCountLsb = 8;
  localparam int unsigned StatusOvfLsb   = 16;

  // Only the byte/half/word codes (and their unsigned aliases) perform stores.
  function automatic logic storeSizeValid(input logic [2:0] size);
    return (size == SizeB) || (size == SizeH) || (size == SizeW) ||
           (size == SizeBu) || (size == SizeHu);
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Byte-wide console FIFO; a push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle.
module tx_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [7:0]             pushData,
  input  logic                   pop,
  output logic [7:0]             headData,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = DEPTH[PtrW:0];

  logic [7:0]      store [DEPTH];
  logic [PtrW-1:0] wrPtrQ, rdPtrQ;
  logic [PtrW:0]   countQ;
  logic            pushOk, popOk;

  assign full     = (countQ == FullCount);
  assign empty    = (countQ == '0);
  assign count    = countQ;
  assign headData = store[rdPtrQ];
  assign pushOk   = push && (!full || pop);
  assign popOk    = pop && !empty;

  always_ff @(posedge clk) begin
    if (pushOk) begin
      store[wrPtrQ] <= pushData;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      if (pushOk) wrPtrQ <= wrPtrQ + 1'b1;
      if (popOk)  rdPtrQ <= rdPtrQ + 1'b1;
      countQ <= countQ + {{PtrW{1'b0}}, pushOk} - {{PtrW{1'b0}}, popOk};
    end
  end

endmodule

// File: rtl/dmem_unit.sv
// Data memory for a simple core: word RAM with byte strobes, combinational
// loads, and a 32-byte MMIO window (console TX FIFO, cycle counter, tohost).
module dmem_unit
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned TX_DEPTH    = 8,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmemAddr,
  input  logic [31:0] dmemWdata,
  input  logic [2:0]  dmemSize,
  input  logic        dmemWen,
  output logic [31:0] dmemRdata,
  output logic [7:0]  txData,
  output logic        txValid,
  input  logic        txReady,
  output logic        halt,
  output logic [31:0] haltCode,
  output logic        misalignErr
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW = $clog2(TX_DEPTH) + 1;
  localparam logic [32:0] RamBytes = 33'(DEPTH_WORDS) << 2;
  localparam logic [26:0] MmioPage = MMIO_BASE[31:5];

  logic [31:0]   ram [DEPTH_WORDS];
  logic [AW-1:0] ramIdx;
  logic          isMmio, isRam;
  logic [4:0]    mmioOff;

  logic          storeOk, storeGo, misaligned;
  logic [3:0]    byteEn;
  logic [31:0]   storeLanes;
  logic          ramWe, txPush, toHostWe;

  logic [31:0]   ramWord, loadShifted, loadExt, status, mmioRd;

  logic [63:0]   cycleCntQ;
  logic [15:0]   ovfQ;
  logic          haltQ, misalignQ;
  logic [31:0]   haltCodeQ;

  logic          txPop, txDrop, txFull, txEmpty;
  logic [7:0]    txHead;
  logic [CntW-1:0] txCount;

  assign isMmio  = (dmemAddr[31:5] == MmioPage);
  assign isRam   = !isMmio && ({1'b0, dmemAddr} < RamBytes);
  assign ramIdx  = dmemAddr[AW+1:2];
  assign mmioOff = dmemAddr[4:0];

  // Store decode: strobes follow the low address bits; size[2] only marks unsigned loads.
  always_comb begin
    byteEn     = 4'b1111;
    misaligned = 1'b0;
    case (dmemSize[1:0])
      2'b00: begin
        byteEn = 4'b0001 << dmemAddr[1:0];
      end
      2'b01: begin
        byteEn     = dmemAddr[1] ? 4'b1100 : 4'b0011;
        misaligned = dmemAddr[0];
      end
      default: begin
        byteEn     = 4'b1111;
        misaligned = |dmemAddr[1:0];
      end
    endcase
    storeOk  = dmemWen && rst && !haltQ && storeSizeValid(dmemSize);
    storeGo  = storeOk && !misaligned;
    ramWe    = storeGo && isRam;
    txPush   = storeGo && isMmio && (mmioOff == MmioTx);
    toHostWe = storeGo && isMmio && (mmioOff == MmioToHost) && (dmemWdata != '0);
  end

  assign storeLanes = dmemWdata << {dmemAddr[1:0], 3'b000};

  always_ff @(posedge clk) begin
    if (ramWe) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) ram[ramIdx][8*i +: 8] <= storeLanes[8*i +: 8];
      end
    end
  end

  assign ramWord     = isRam ? ram[ramIdx] : '0;
  assign loadShifted = ramWord >> {dmemAddr[1:0], 3'b000};

  always_comb begin
    loadExt = loadShifted;
    case (size_e'(dmemSize))
      SizeB:   loadExt = {{24{loadShifted[7]}}, loadShifted[7:0]};
      SizeH:   loadExt = {{16{loadShifted[15]}}, loadShifted[15:0]};
      SizeBu:  loadExt = {24'b0, loadShifted[7:0]};
      SizeHu:  loadExt = {16'b0, loadShifted[15:0]};
      default: loadExt = loadShifted;
    endcase
  end

  always_comb begin
    status = '0;
    status[StatusFullBit]       = txFull;
    status[StatusEmptyBit]      = txEmpty;
    status[StatusCountLsb +: 8] = 8'(txCount);
    status[StatusOvfLsb +: 16]  = ovfQ;
    case (mmioOff)
      MmioStatus: mmioRd = status;
      MmioCycLo:  mmioRd = cycleCntQ[31:0];
      MmioCycHi:  mmioRd = cycleCntQ[63:32];
      MmioToHost: mmioRd = haltCodeQ;
      default:    mmioRd = '0;
    endcase
  end

  assign dmemRdata = isMmio ? mmioRd : loadExt;

  assign txPop  = txReady && !txEmpty;
  assign txDrop = txPush && txFull && !txPop;

  tx_fifo #(
    .DEPTH (TX_DEPTH)
  ) uTxFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (txPush),
    .pushData (dmemWdata[7:0]),
    .pop      (txPop),
    .headData (txHead),
    .full     (txFull),
    .empty    (txEmpty),
    .count    (txCount)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      cycleCntQ <= '0;
      ovfQ      <= '0;
      haltQ     <= 1'b0;
      haltCodeQ <= '0;
      misalignQ <= 1'b0;
    end else begin
      cycleCntQ <= cycleCntQ + 64'd1;
      if (txDrop && (ovfQ != 16'hFFFF)) ovfQ <= ovfQ + 16'd1;
      if (toHostWe) begin
        haltQ     <= 1'b1;
        haltCodeQ <= dmemWdata;
      end
      if (storeOk && misaligned) misalignQ <= 1'b1;
    end
  end

  assign txData      = txHead;
  assign txValid     = !txEmpty;
  assign halt        = haltQ;
  assign haltCode    = haltCodeQ;
  assign misalignErr = misalignQ;

endmodule

// File: tb/tb_dmem_unit.sv
// Randomised self-checking bench for dmem_unit against a byte-level reference
// model, plus directed scenarios for the documented corner cases.
module tb_dmem_unit;

  localparam int unsigned Depth    = 256;
  localparam int unsigned TxDepth  = 8;
  localparam logic [31:0] MmioBase = 32'h8000_0000;
  localparam logic [31:0] AddrTx   = MmioBase + 32'h00;
  localparam logic [31:0] AddrStat = MmioBase + 32'h04;
  localparam logic [31:0] AddrCycL = MmioBase + 32'h08;
  localparam logic [31:0] AddrCycH = MmioBase + 32'h0C;
  localparam logic [31:0] AddrHost = MmioBase + 32'h10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] dmemAddr = AddrStat;
  logic [31:0] dmemWdata = '0;
  logic [2:0]  dmemSize = 3'b010;
  logic        dmemWen = 1'b0;
  logic        txReady = 1'b0;
  logic [31:0] dmemRdata;
  logic [7:0]  txData;
  logic        txValid;
  logic        halt;
  logic [31:0] haltCode;
  logic        misalignErr;

  dmem_unit #(
    .DEPTH_WORDS (Depth),
    .TX_DEPTH    (TxDepth),
    .MMIO_BASE   (MmioBase)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dmemAddr    (dmemAddr),
    .dmemWdata   (dmemWdata),
    .dmemSize    (dmemSize),
    .dmemWen     (dmemWen),
    .dmemRdata   (dmemRdata),
    .txData      (txData),
    .txValid     (txValid),
    .txReady     (txReady),
    .halt        (halt),
    .haltCode    (haltCode),
    .misalignErr (misalignErr)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;
  bit chkOn = 1'b0;
  bit rdyCur = 1'b0;

  // Reference model state
  logic [7:0]      refMem [4*Depth];
  logic [7:0]      refQ [$];
  int              refOvf = 0;
  longint unsigned refCyc = 0;
  bit              refHalt = 1'b0;
  logic [31:0]     refCode = '0;
  bit              refMis = 1'b0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit inMmio(input logic [31:0] a);
    return (a >= MmioBase) && (a < MmioBase + 32);
  endfunction

  function automatic int accessBytes(input logic [2:0] s);
    if (s == 3'b000 || s == 3'b100) return 1;
    if (s == 3'b001 || s == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] refLoad(input logic [31:0] a, input logic [2:0] s);
    logic [31:0] v;
    int n;
    v = '0;
    if (inMmio(a)) begin
      case (a - MmioBase)
        32'd4:   v = (32'(refOvf) << 16) | (32'(refQ.size()) << 8) |
                     (32'(refQ.size() == 0) << 1) | 32'(refQ.size() == TxDepth);
        32'd8:   v = refCyc[31:0];
        32'd12:  v = refCyc[63:32];
        32'd16:  v = refCode;
        default: v = '0;
      endcase
      return v;
    end
    if (a >= 4*Depth) return '0;
    n = accessBytes(s);
    // Bytes beyond the end of the addressed word read as zero.
    for (int i = 0; i < n; i++) begin
      if ((a % 4) + i < 4) v = v | (32'(refMem[a+i]) << (8*i));
    end
    if (s == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
    if (s == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic refStep(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] s,
                         input logic we, input logic rdy, input logic rs);
    bit pop, push, ok, mis;
    int n;
    if (!rs) begin
      refQ.delete();
      refOvf  = 0;
      refCyc  = 0;
      refHalt = 1'b0;
      refCode = '0;
      refMis  = 1'b0;
      return;
    end
    pop  = (refQ.size() > 0) && rdy;
    n    = accessBytes(s);
    ok   = we && !refHalt && (s inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis  = ok && ((a % n) != 0);
    push = 1'b0;
    if (ok && !mis) begin
      if (inMmio(a)) begin
        if (a == AddrTx) push = 1'b1;
        if (a == AddrHost && wd != 0) begin
          refHalt = 1'b1;
          refCode = wd;
        end
      end else if (a < 4*Depth) begin
        for (int i = 0; i < n; i++) refMem[a+i] = wd[8*i +: 8];
      end
    end
    if (mis) refMis = 1'b1;
    if (pop) void'(refQ.pop_front());
    if (push) begin
      if (refQ.size() < TxDepth) refQ.push_back(wd[7:0]);
      else if (refOvf < 65535) refOvf++;
    end
    refCyc++;
  endtask

  // One bus cycle: drive at negedge, check combinational/state outputs, clock, model.
  task automatic doCycle(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] s,
                         input logic we, output logic [31:0] rd);
    dmemAddr  = a;
    dmemWdata = wd;
    dmemSize  = s;
    dmemWen   = we;
    txReady   = rdyCur;
    #1;
    rd = dmemRdata;
    if (chkOn) begin
      checkVal("rdata", dmemRdata, refLoad(a, s));
      checkVal("txValid", {31'b0, txValid}, {31'b0, refQ.size() > 0});
      if (refQ.size() > 0) checkVal("txData", {24'b0, txData}, {24'b0, refQ[0]});
      checkVal("halt", {31'b0, halt}, {31'b0, refHalt});
      checkVal("haltCode", haltCode, refCode);
      checkVal("misalignErr", {31'b0, misalignErr}, {31'b0, refMis});
    end
    @(posedge clk);
    refStep(a, wd, s, we, rdyCur, rst);
    @(negedge clk);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] s);
    logic [31:0] unused;
    doCycle(a, wd, s, 1'b1, unused);
  endtask

  task automatic ld(input logic [31:0] a, input logic [2:0] s, output logic [31:0] rd);
    doCycle(a, 32'h0, s, 1'b0, rd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd, prior;
    logic [31:0] a, wd;
    logic [2:0]  s;
    logic        we;
    int          r;

    for (int i = 0; i < 4*Depth; i++) refMem[i] = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) ld(AddrStat, 3'b010, rd);
    chkOn = 1'b1;

    #1;
    checkVal("rst_txValid", {31'b0, txValid}, 32'h0);
    checkVal("rst_halt", {31'b0, halt}, 32'h0);
    checkVal("rst_haltCode", haltCode, 32'h0);
    checkVal("rst_misalign", {31'b0, misalignErr}, 32'h0);
    ld(AddrStat, 3'b010, rd);
    checkVal("rst_status", rd, 32'h0000_0002);

    // Counter counts edges out of reset.
    rst = 1'b1;
    for (int i = 0; i < 10; i++) ld(AddrCycL, 3'b010, rd);
    ld(AddrCycL, 3'b010, rd);
    checkVal("cyc_lo_10", rd, 32'd10);
    ld(AddrCycH, 3'b010, rd);
    checkVal("cyc_hi_0", rd, 32'd0);

    for (int w = 0; w < Depth; w++) st(32'(4*w), $urandom, 3'b010);

    st(32'h100, 32'hDEAD_BEEF, 3'b010);
    ld(32'h103, 3'b000, rd);
    checkVal("lb_103", rd, 32'hFFFF_FFDE);
    ld(32'h102, 3'b101, rd);
    checkVal("lhu_102", rd, 32'h0000_DEAD);
    ld(32'h100, 3'b010, rd);
    checkVal("lw_100", rd, 32'hDEAD_BEEF);

    // Read during a store observes old contents.
    doCycle(32'h100, 32'h0BAD_F00D, 3'b010, 1'b1, rd);
    checkVal("rd_during_wr", rd, 32'hDEAD_BEEF);
    st(32'h100, 32'hDEAD_BEEF, 3'b010);

    checkVal("mis_before", {31'b0, misalignErr}, 32'h0);
    st(32'h101, 32'h0000_1234, 3'b001);
    ld(32'h100, 3'b010, rd);
    checkVal("mis_ram_kept", rd, 32'hDEAD_BEEF);
    checkVal("mis_set", {31'b0, misalignErr}, 32'h1);
    ld(32'h0, 3'b010, rd);
    checkVal("mis_sticky", {31'b0, misalignErr}, 32'h1);

    rdyCur = 1'b1;
    st(AddrTx, 32'h0000_0041, 3'b000);
    #1;
    checkVal("tx1_valid", {31'b0, txValid}, 32'h1);
    checkVal("tx1_data", {24'b0, txData}, 32'h41);
    ld(AddrStat, 3'b010, rd);
    ld(AddrStat, 3'b010, rd);
    checkVal("tx1_status_empty", rd, 32'h0000_0002);

    rdyCur = 1'b0;
    for (int i = 0; i < 9; i++) st(AddrTx, 32'h30 + 32'(i), 3'b010);
    ld(AddrStat, 3'b010, rd);
    checkVal("ovf_status", rd, 32'h0001_0801);
    rdyCur = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checkVal("drain_valid", {31'b0, txValid}, 32'h1);
      checkVal("drain_data", {24'b0, txData}, 32'h30 + 32'(i));
      ld(AddrStat, 3'b010, rd);
    end
    #1;
    checkVal("drain_done", {31'b0, txValid}, 32'h0);

    // Reset while bytes are queued; the coincident store must be dropped.
    rdyCur = 1'b0;
    for (int i = 0; i < 3; i++) st(AddrTx, 32'h60 + 32'(i), 3'b000);
    rst = 1'b0;
    st(32'h100, 32'h1111_1111, 3'b010);
    rst = 1'b1;
    #1;
    checkVal("rstq_txValid", {31'b0, txValid}, 32'h0);
    checkVal("rstq_misalign", {31'b0, misalignErr}, 32'h0);
    ld(32'h100, 3'b010, rd);
    checkVal("rst_store_drop", rd, 32'hDEAD_BEEF);

    for (int c = 0; c < 1500; c++) begin
      r = $urandom_range(0, 99);
      if (r < 45)       a = $urandom_range(0, 4*Depth + 63);
      else if (r < 70)  a = MmioBase + 4 * $urandom_range(0, 7);
      else if (r < 80)  a = AddrTx;
      else if (r < 95)  a = MmioBase + $urandom_range(0, 31);
      else              a = $urandom;
      s  = 3'($urandom_range(0, 7));
      we = ($urandom_range(0, 2) == 0);
      wd = $urandom;
      if (a == AddrHost) wd = 32'h0;
      rdyCur = (c < 750) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      doCycle(a, wd, s, we, rd);
    end

    rdyCur = 1'b1;
    force dut.cycleCntQ = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.cycleCntQ;
    refCyc = 64'h0000_0000_FFFF_FFFF;
    ld(AddrCycL, 3'b010, rd);
    checkVal("cyc_lo_max", rd, 32'hFFFF_FFFF);
    ld(AddrCycH, 3'b010, rd);
    checkVal("cyc_hi_carry", rd, 32'h0000_0001);

    ld(32'h100, 3'b010, prior);
    st(AddrHost, 32'h0000_002A, 3'b010);
    st(AddrHost, 32'h0000_0007, 3'b010);
    #1;
    checkVal("halt_set", {31'b0, halt}, 32'h1);
    checkVal("halt_code", haltCode, 32'h0000_002A);
    ld(AddrHost, 3'b010, rd);
    checkVal("tohost_rd", rd, 32'h0000_002A);
    st(32'h100, 32'h5555_AAAA, 3'b010);
    ld(32'h100, 3'b010, rd);
    checkVal("halt_store_ign", rd, prior);
    st(AddrTx, 32'h77, 3'b000);
    ld(AddrStat, 3'b010, rd);
    checkVal("halt_tx_ign", rd[15:0], 16'h0002);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
